// File: rtl/counter_arbiter_if.sv
// Request/grant bus between two requesters and the shared counter arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface counter_arbiter_if #(
  parameter int WIDTH = 5
);
  // Handshake: req[i] is a level request held high by requester i until it is served.
  // A grant is the cycle gnt[i] rises. The granted limit is captured on that edge.
  // gnt[i] stays high for the whole count. done[i] pulses for one cycle when the count ends.
  // A request that is still high after done is treated as a new request.
  logic [1:0]       req;
  logic [WIDTH-1:0] limit0;
  logic [WIDTH-1:0] limit1;
  logic [1:0]       gnt;
  logic             busy;
  logic [WIDTH-1:0] q;
  logic [1:0]       done;

  modport master (
    output req, limit0, limit1,
    input  gnt, busy, q, done
  );

  modport slave (
    input  req, limit0, limit1,
    output gnt, busy, q, done
  );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to two requesters (IDLE/COUNT/DONE).
// Optional macro COUNTER_ARB_ABORT_EN: dropping the granted req during COUNT aborts the count.
module counter_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  counter_arbiter_if.slave  bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic             busy_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] limit_q;
  logic             last_q;

  logic             win_d;
  logic [1:0]       gnt_d;
  logic [WIDTH-1:0] limit_d;

  // A single request wins outright; a contested grant goes to the one not served last.
  always_comb begin
    win_d = bus.req[1];
    if (&bus.req) begin
      win_d = ~last_q;
    end
    gnt_d   = win_d ? 2'b10 : 2'b01;
    limit_d = win_d ? bus.limit1 : bus.limit0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      q_q     <= '0;
      limit_q <= '0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 2'b00;
          q_q    <= '0;
          if (|bus.req) begin
            state_q <= COUNT;
            gnt_q   <= gnt_d;
            busy_q  <= 1'b1;
            limit_q <= limit_d;
            last_q  <= win_d;
          end
        end
        COUNT: begin
`ifdef COUNTER_ARB_ABORT_EN
          if (!(|(bus.req & gnt_q))) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            q_q     <= '0;
          end else
`endif
          // Stop on the limit rather than wrapping, so the maximum limit is reachable.
          if (q_q == limit_q) begin
            state_q <= DONE;
            done_q  <= gnt_q;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
          end else begin
            q_q <= q_q + WIDTH'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 2'b00;
          q_q     <= '0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          done_q  <= 2'b00;
          busy_q  <= 1'b0;
          q_q     <= '0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.q    = q_q;
  assign bus.done = done_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: queue-based cycle model checked every cycle plus directed literal checks.
module tb_counter_arbiter;
  localparam int W  = 5;
  localparam int OW = 2 + 1 + W + 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  bit         started = 1'b0;

  always #5 clk = ~clk;

  counter_arbiter_if #(.WIDTH(W)) bus ();

  counter_arbiter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [OW-1:0] pack(logic [1:0] g, logic b, logic [W-1:0] qv, logic [1:0] d);
    return {g, b, qv, d};
  endfunction

  task automatic check(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got {gnt,busy,q,done}=%b want %b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each grant expands into its whole future: L+1 counting cycles then one done cycle.
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] m_cur;
  bit            m_idle;
  bit            m_counting;
  int            m_last;
  int            m_owner;

  always @(posedge clk or posedge reset) begin
    bit         abort;
    int         w;
    int         lim;
    logic [1:0] oh;
    if (reset) begin
      exp_q.delete();
      m_cur      = '0;
      m_idle     = 1'b1;
      m_counting = 1'b0;
      m_last     = 1;
      m_owner    = 0;
    end else begin
      abort = 1'b0;
`ifdef COUNTER_ARB_ABORT_EN
      if (m_counting && !bus.req[m_owner]) abort = 1'b1;
`endif
      if (abort) begin
        exp_q.delete();
        m_cur      = '0;
        m_idle     = 1'b1;
        m_counting = 1'b0;
      end else if (exp_q.size() > 0) begin
        m_cur      = exp_q.pop_front();
        m_idle     = 1'b0;
        m_counting = m_cur[W+2];
      end else if (m_idle && bus.req != 2'b00) begin
        if (bus.req == 2'b11) w = 1 - m_last;
        else                  w = bus.req[1] ? 1 : 0;
        m_last  = w;
        m_owner = w;
        lim     = (w == 1) ? int'(bus.limit1) : int'(bus.limit0);
        oh      = (w == 1) ? 2'b10 : 2'b01;
        for (int k = 0; k <= lim; k++) exp_q.push_back(pack(oh, 1'b1, W'(k), 2'b00));
        exp_q.push_back(pack(2'b00, 1'b0, W'(lim), oh));
        m_cur      = exp_q.pop_front();
        m_idle     = 1'b0;
        m_counting = 1'b1;
      end else begin
        m_cur      = '0;
        m_idle     = 1'b1;
        m_counting = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (started) check("model", pack(bus.gnt, bus.busy, bus.q, bus.done), m_cur);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(logic [1:0] r, logic [W-1:0] l0, logic [W-1:0] l1);
    @(negedge clk);
    bus.req    = r;
    bus.limit0 = l0;
    bus.limit1 = l1;
  endtask

  task automatic expect_cyc(string name, logic [1:0] g, logic b, logic [W-1:0] qv, logic [1:0] d);
    @(posedge clk);
    #1;
    check(name, pack(bus.gnt, bus.busy, bus.q, bus.done), pack(g, b, qv, d));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset      = 1'b0;
    bus.req    = 2'b00;
    bus.limit0 = '0;
    bus.limit1 = '0;

    // Reset window with no requests: everything stays zero.
    #10;
    reset   = 1'b1;
    started = 1'b1;
    #1;
    check("rst_async", pack(bus.gnt, bus.busy, bus.q, bus.done), '0);
    #29;
    reset = 1'b0;
    repeat (3) expect_cyc("idle_noreq", 2'b00, 1'b0, '0, 2'b00);

    // Single requester, limit 3; a later limit change must not matter.
    drive(2'b01, 5'd3, 5'd0);
    expect_cyc("r0_q0", 2'b01, 1'b1, 5'd0, 2'b00);
    @(negedge clk) bus.limit0 = 5'd7;
    expect_cyc("r0_q1", 2'b01, 1'b1, 5'd1, 2'b00);
    expect_cyc("r0_q2", 2'b01, 1'b1, 5'd2, 2'b00);
    expect_cyc("r0_q3", 2'b01, 1'b1, 5'd3, 2'b00);
    expect_cyc("r0_done", 2'b00, 1'b0, 5'd3, 2'b01);
    drive(2'b00, 5'd7, 5'd0);
    expect_cyc("r0_idle", 2'b00, 1'b0, 5'd0, 2'b00);

    // Fresh reset, then both requesting: order 0,1,0 with DONE+IDLE between.
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    drive(2'b11, 5'd2, 5'd1);
    expect_cyc("rr_a_q0", 2'b01, 1'b1, 5'd0, 2'b00);
    expect_cyc("rr_a_q1", 2'b01, 1'b1, 5'd1, 2'b00);
    expect_cyc("rr_a_q2", 2'b01, 1'b1, 5'd2, 2'b00);
    expect_cyc("rr_a_done", 2'b00, 1'b0, 5'd2, 2'b01);
    expect_cyc("rr_a_idle", 2'b00, 1'b0, 5'd0, 2'b00);
    expect_cyc("rr_b_q0", 2'b10, 1'b1, 5'd0, 2'b00);
    expect_cyc("rr_b_q1", 2'b10, 1'b1, 5'd1, 2'b00);
    expect_cyc("rr_b_done", 2'b00, 1'b0, 5'd1, 2'b10);
    expect_cyc("rr_b_idle", 2'b00, 1'b0, 5'd0, 2'b00);
    expect_cyc("rr_c_q0", 2'b01, 1'b1, 5'd0, 2'b00);
    drive(2'b00, 5'd2, 5'd1);
    repeat (5) @(posedge clk);

    // Maximum limit: climbs to 31 without wrapping, then a zero limit.
    drive(2'b10, 5'd2, 5'd31);
    for (int k = 0; k < 32; k++) expect_cyc("max_cnt", 2'b10, 1'b1, W'(k), 2'b00);
    expect_cyc("max_done", 2'b00, 1'b0, 5'd31, 2'b10);
    drive(2'b00, 5'd2, 5'd31);
    expect_cyc("max_idle", 2'b00, 1'b0, 5'd0, 2'b00);
    drive(2'b10, 5'd2, 5'd0);
    expect_cyc("zero_q0", 2'b10, 1'b1, 5'd0, 2'b00);
    expect_cyc("zero_done", 2'b00, 1'b0, 5'd0, 2'b10);
    drive(2'b00, 5'd2, 5'd0);
    expect_cyc("zero_idle", 2'b00, 1'b0, 5'd0, 2'b00);

    // Granted request dropped at q=2 with limit 5.
    drive(2'b01, 5'd5, 5'd0);
    expect_cyc("drop_q0", 2'b01, 1'b1, 5'd0, 2'b00);
    expect_cyc("drop_q1", 2'b01, 1'b1, 5'd1, 2'b00);
    expect_cyc("drop_q2", 2'b01, 1'b1, 5'd2, 2'b00);
    drive(2'b00, 5'd5, 5'd0);
`ifdef COUNTER_ARB_ABORT_EN
    expect_cyc("drop_abort", 2'b00, 1'b0, 5'd0, 2'b00);
    expect_cyc("drop_abort_idle", 2'b00, 1'b0, 5'd0, 2'b00);
`else
    expect_cyc("drop_q3", 2'b01, 1'b1, 5'd3, 2'b00);
    expect_cyc("drop_q4", 2'b01, 1'b1, 5'd4, 2'b00);
    expect_cyc("drop_q5", 2'b01, 1'b1, 5'd5, 2'b00);
    expect_cyc("drop_done", 2'b00, 1'b0, 5'd5, 2'b01);
    expect_cyc("drop_idle", 2'b00, 1'b0, 5'd0, 2'b00);
`endif

    // Reset mid-count at q=4, then a contested grant must go to requester 0.
    drive(2'b01, 5'd9, 5'd0);
    for (int k = 0; k < 5; k++) expect_cyc("mid_cnt", 2'b01, 1'b1, W'(k), 2'b00);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid", pack(bus.gnt, bus.busy, bus.q, bus.done), '0);
    expect_cyc("rst_mid_hold", 2'b00, 1'b0, 5'd0, 2'b00);
    @(negedge clk);
    reset      = 1'b0;
    bus.req    = 2'b11;
    bus.limit0 = 5'd1;
    bus.limit1 = 5'd1;
    expect_cyc("post_rst_gnt0", 2'b01, 1'b1, 5'd0, 2'b00);
    expect_cyc("post_rst_q1", 2'b01, 1'b1, 5'd1, 2'b00);
    expect_cyc("post_rst_done", 2'b00, 1'b0, 5'd1, 2'b01);
    expect_cyc("post_rst_idle", 2'b00, 1'b0, 5'd0, 2'b00);
    expect_cyc("post_rst_gnt1", 2'b10, 1'b1, 5'd0, 2'b00);
    drive(2'b00, 5'd1, 5'd1);
    repeat (6) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
